// File: rtl/alu16_sched_if.sv
// Requester and response channels of the alu16_sched round-robin ALU scheduler.
// Every channel transfers on a cycle where valid and ready are both high; valid never waits on ready.
interface alu16_sched_if #(
  parameter int WIDTH = 16,
  parameter int OPW   = 4
);
  logic             req0_valid;
  logic             req0_ready;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;
  logic [OPW-1:0]   req0_op;
  logic             req1_valid;
  logic             req1_ready;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;
  logic [OPW-1:0]   req1_op;
  logic             rsp_valid;
  logic             rsp_ready;
  logic             rsp_id;
  logic [WIDTH-1:0] rsp_out;
  logic [3:0]       rsp_flags;

  modport master (
    output req0_valid, req0_a, req0_b, req0_op,
    input  req0_ready,
    output req1_valid, req1_a, req1_b, req1_op,
    input  req1_ready,
    input  rsp_valid, rsp_id, rsp_out, rsp_flags,
    output rsp_ready
  );

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_op,
    output req0_ready,
    input  req1_valid, req1_a, req1_b, req1_op,
    output req1_ready,
    output rsp_valid, rsp_id, rsp_out, rsp_flags,
    input  rsp_ready
  );
endinterface

// File: rtl/alu16_sched.sv
// Shares one external ALU16 between two requesters; multi-bit shifts are built by
// iterating the ALU's single-bit shift ops with the result fed back as the operand.
module alu16_sched #(
  parameter int WIDTH = 16,
  parameter int OPW   = 4,
  parameter int SHW   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  alu16_sched_if.slave     bus,
  output logic             busy,
  output logic [1:0]       state_dbg,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [OPW-1:0]   alu_control,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_zero,
  input  logic             alu_carry,
  input  logic             alu_overflow,
  input  logic             alu_negative
);
  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_t;

  localparam logic [OPW-1:0] OP_SLL = OPW'(5);
  localparam logic [OPW-1:0] OP_SRL = OPW'(6);
  localparam logic [OPW-1:0] OP_SRA = OPW'(7);

  state_t           state;
  logic             last_grant;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] b_reg;
  logic [OPW-1:0]   op_reg;
  logic [SHW-1:0]   cnt;
  logic [WIDTH-1:0] rsp_out_r;
  logic [3:0]       rsp_flags_r;
  logic             rsp_id_r;

  logic             grant0, grant1, accept;
  logic [WIDTH-1:0] sel_a, sel_b;
  logic [OPW-1:0]   sel_op;

  function automatic logic is_shift(input logic [OPW-1:0] op);
    return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
  endfunction

  // On a tie the requester that was not served last wins.
  assign grant0 = bus.req0_valid && (!bus.req1_valid || last_grant);
  assign grant1 = bus.req1_valid && (!bus.req0_valid || !last_grant);

  assign bus.req0_ready = rst_n && (state == IDLE) && grant0;
  assign bus.req1_ready = rst_n && (state == IDLE) && grant1;
  assign accept         = bus.req0_ready || bus.req1_ready;

  assign sel_a  = grant1 ? bus.req1_a  : bus.req0_a;
  assign sel_b  = grant1 ? bus.req1_b  : bus.req0_b;
  assign sel_op = grant1 ? bus.req1_op : bus.req0_op;

  assign alu_a       = acc;
  assign alu_b       = b_reg;
  assign alu_control = op_reg;

  assign bus.rsp_valid = (state == RESP);
  assign bus.rsp_id    = rsp_id_r;
  assign bus.rsp_out   = rsp_out_r;
  assign bus.rsp_flags = rsp_flags_r;
  assign busy          = (state != IDLE);
  assign state_dbg     = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      last_grant  <= 1'b1;
      acc         <= '0;
      b_reg       <= '0;
      op_reg      <= '0;
      cnt         <= '0;
      rsp_out_r   <= '0;
      rsp_flags_r <= '0;
      rsp_id_r    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            acc        <= sel_a;
            b_reg      <= sel_b;
            op_reg     <= sel_op;
            cnt        <= sel_b[SHW-1:0];
            rsp_id_r   <= grant1;
            last_grant <= grant1;
            if (sel_op[OPW-1]) begin
              rsp_out_r   <= '0;
              rsp_flags_r <= 4'b1000;
              state       <= RESP;
            end else if (is_shift(sel_op) && (sel_b[SHW-1:0] == '0)) begin
              rsp_out_r   <= sel_a;
              rsp_flags_r <= {(sel_a == '0), 1'b0, 1'b0, sel_a[WIDTH-1]};
              state       <= RESP;
            end else begin
              state <= EXEC;
            end
          end
        end
        EXEC: begin
          if (is_shift(op_reg)) begin
            acc <= alu_out;
            cnt <= cnt - SHW'(1);
            // Flags reported for a shift are those of the final single-bit pass.
            if (cnt == SHW'(1)) begin
              rsp_out_r   <= alu_out;
              rsp_flags_r <= {alu_zero, alu_carry, alu_overflow, alu_negative};
              state       <= RESP;
            end
          end else begin
            rsp_out_r   <= alu_out;
            rsp_flags_r <= {alu_zero, alu_carry, alu_overflow, alu_negative};
            state       <= RESP;
          end
        end
        RESP: begin
          if (bus.rsp_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu16_sched.sv
// Directed bench for alu16_sched with a behavioural ALU16 on the datapath ports and
// a queue-based scoreboard checking id, result, flags and response latency.
module tb_alu16_sched;
  localparam logic [3:0] op_add = 4'b0000;
  localparam logic [3:0] op_sub = 4'b0001;
  localparam logic [3:0] op_and = 4'b0010;
  localparam logic [3:0] op_xor = 4'b0100;
  localparam logic [3:0] op_sll = 4'b0101;
  localparam logic [3:0] op_srl = 4'b0110;
  localparam logic [3:0] op_sra = 4'b0111;
  localparam logic [3:0] op_rsv = 4'b1000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        busy;
  logic [1:0]  state_dbg;
  logic [15:0] alu_a, alu_b, alu_out;
  logic [3:0]  alu_control;
  logic        alu_zero, alu_carry, alu_overflow, alu_negative;
  logic [16:0] alu_t;

  alu16_sched_if #(.WIDTH(16), .OPW(4)) bus ();

  alu16_sched #(.WIDTH(16), .OPW(4), .SHW(4)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .busy(busy), .state_dbg(state_dbg),
    .alu_a(alu_a), .alu_b(alu_b), .alu_control(alu_control), .alu_out(alu_out),
    .alu_zero(alu_zero), .alu_carry(alu_carry), .alu_overflow(alu_overflow),
    .alu_negative(alu_negative)
  );

  // clock and cycle counter
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // behavioural ALU16: carry is carry-out for add, borrow for sub, shifted-out bit for shifts
  always_comb begin
    alu_t = '0;
    alu_out = '0;
    alu_carry = 1'b0;
    alu_overflow = 1'b0;
    case (alu_control)
      op_add: begin
        alu_t = {1'b0, alu_a} + {1'b0, alu_b};
        alu_out = alu_t[15:0];
        alu_carry = alu_t[16];
        alu_overflow = (alu_a[15] == alu_b[15]) && (alu_out[15] != alu_a[15]);
      end
      op_sub: begin
        alu_out = alu_a - alu_b;
        alu_carry = (alu_a < alu_b);
        alu_overflow = (alu_a[15] != alu_b[15]) && (alu_out[15] != alu_a[15]);
      end
      op_and: alu_out = alu_a & alu_b;
      4'b0011: alu_out = alu_a | alu_b;
      op_xor: alu_out = alu_a ^ alu_b;
      op_sll: begin alu_out = {alu_a[14:0], 1'b0}; alu_carry = alu_a[15]; end
      op_srl: begin alu_out = {1'b0, alu_a[15:1]}; alu_carry = alu_a[0]; end
      op_sra: begin alu_out = {alu_a[15], alu_a[15:1]}; alu_carry = alu_a[0]; end
      default: alu_out = '0;
    endcase
    alu_zero = (alu_out == 16'h0000);
    alu_negative = alu_out[15];
  end

  // scoreboard state
  int n_cmp = 0;
  int n_fail = 0;
  logic [20:0] exp_q[$];
  int due_q[$];
  bit grant_q[$];
  int acc_cyc[2];
  int hs_cyc = 0;
  logic prev_v = 1'b0;
  logic [20:0] snap = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // driver: present one op, wait for its grant, record the expected response
  task automatic issue(input bit id, input logic [15:0] a, input logic [15:0] b,
                       input logic [3:0] op, input bit chk, input logic [15:0] eo,
                       input logic [3:0] ef, input int lat);
    int n;
    bit done;
    n = 0;
    done = 1'b0;
    if (id == 1'b0) begin
      bus.req0_a = a; bus.req0_b = b; bus.req0_op = op; bus.req0_valid = 1'b1;
    end else begin
      bus.req1_a = a; bus.req1_b = b; bus.req1_op = op; bus.req1_valid = 1'b1;
    end
    while (!done && n < 60) begin
      @(negedge clk);
      n++;
      if ((id == 1'b0 && bus.req0_ready) || (id == 1'b1 && bus.req1_ready)) begin
        done = 1'b1;
        grant_q.push_back(id);
        acc_cyc[id] = cyc;
        if (chk) begin
          exp_q.push_back({id, eo, ef});
          due_q.push_back(cyc + lat);
        end
      end
    end
    if (!done) begin
      n_cmp++;
      n_fail++;
      $display("FAIL accept_timeout id=%0d: got no ready expected ready within 60 cycles", id);
    end
    @(posedge clk);
    #1;
    if (id == 1'b0) bus.req0_valid = 1'b0;
    else bus.req1_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || bus.rsp_valid) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      n_cmp++;
      n_fail++;
      $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
    end
    @(posedge clk);
    #1;
  endtask

  // monitor: latency on first presentation, stability while stalled, contents on handshake
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_v = 1'b0;
    end else begin
      if (bus.rsp_valid && !prev_v) begin
        snap = {bus.rsp_id, bus.rsp_out, bus.rsp_flags};
        if (due_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_rsp: got %h expected no response", snap);
        end else begin
          check("rsp_latency", cyc, due_q[0]);
        end
      end else if (bus.rsp_valid) begin
        check("rsp_stable", {bus.rsp_id, bus.rsp_out, bus.rsp_flags}, snap);
        check("busy_in_resp", busy, 1);
      end
      if (bus.rsp_valid && bus.rsp_ready) begin
        hs_cyc = cyc;
        if (exp_q.size() > 0) begin
          check("rsp_id_out_flags", {bus.rsp_id, bus.rsp_out, bus.rsp_flags}, exp_q.pop_front());
          void'(due_q.pop_front());
        end
      end
      prev_v = bus.rsp_valid;
    end
  end

  initial begin
    int n;
    bus.req0_valid = 1'b0; bus.req0_a = '0; bus.req0_b = '0; bus.req0_op = '0;
    bus.req1_valid = 1'b0; bus.req1_a = '0; bus.req1_b = '0; bus.req1_op = '0;
    bus.rsp_ready = 1'b1;

    // reset state, with a requester asserting valid during reset
    rst_n = 1'b0;
    bus.req0_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_req0_ready", bus.req0_ready, 0);
    check("reset_rsp_valid", bus.rsp_valid, 0);
    check("reset_busy", busy, 0);
    check("reset_state", state_dbg, 0);
    check("reset_alu_drive", {alu_a, alu_b, alu_control}, 0);
    check("reset_rsp_regs", {bus.rsp_id, bus.rsp_out, bus.rsp_flags}, 0);
    bus.req0_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // simple add, response two cycles after accept
    issue(1'b0, 16'h0001, 16'h0001, op_add, 1'b1, 16'h0002, 4'b0000, 2);
    drain();

    // round-robin from reset with both requesters holding valid
    grant_q.delete();
    fork
      begin
        rst_n = 1'b0;
        @(negedge clk);
        check("rr_reset_ready", {bus.req0_ready, bus.req1_ready}, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
      end
      begin
        repeat (2) issue(1'b0, 16'h0002, 16'h0001, op_sub, 1'b1, 16'h0001, 4'b0000, 2);
      end
      begin
        repeat (2) issue(1'b1, 16'h000F, 16'h00F0, op_and, 1'b1, 16'h0000, 4'b1000, 2);
      end
    join
    drain();
    check("rr_grant_count", grant_q.size(), 4);
    for (int i = 0; i < grant_q.size(); i++) check("rr_grant_order", grant_q[i], i % 2);

    // multi-bit shifts
    issue(1'b1, 16'h0001, 16'h0004, op_sll, 1'b1, 16'h0010, 4'b0000, 5);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("sll_exec_control", {bus.rsp_valid, busy, alu_control}, {2'b01, op_sll});
    end
    drain();
    issue(1'b0, 16'h8000, 16'h000F, op_sra, 1'b1, 16'hFFFF, 4'b0001, 16);
    drain();

    // zero-count shift and reserved op
    issue(1'b0, 16'h0002, 16'h0000, op_srl, 1'b1, 16'h0002, 4'b0000, 1);
    drain();
    issue(1'b1, 16'h1234, 16'h5678, op_rsv, 1'b1, 16'h0000, 4'b1000, 1);
    drain();

    // backpressure with the other requester waiting
    bus.rsp_ready = 1'b0;
    issue(1'b0, 16'h0003, 16'h0004, op_add, 1'b1, 16'h0007, 4'b0000, 2);
    fork
      issue(1'b1, 16'h00FF, 16'h0F0F, op_xor, 1'b1, 16'h0FF0, 4'b0000, 2);
      begin
        n = 0;
        do begin
          @(negedge clk);
          n++;
        end while (!bus.rsp_valid && n < 10);
        check("bp_rsp_valid", bus.rsp_valid, 1);
        for (int i = 0; i < 3; i++) begin
          if (i > 0) @(negedge clk);
          check("bp_req1_ready", bus.req1_ready, 0);
          check("bp_busy", busy, 1);
        end
        @(posedge clk);
        #1;
        bus.rsp_ready = 1'b1;
      end
    join
    check("bp_accept_after_hs", acc_cyc[1], hs_cyc + 1);
    drain();

    // reset during the second EXEC cycle of an 8-bit shift
    issue(1'b0, 16'h0001, 16'h0008, op_sll, 1'b0, 16'h0000, 4'b0000, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_rsp_valid", bus.rsp_valid, 0);
    check("midrst_busy", busy, 0);
    check("midrst_state", state_dbg, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    check("midrst_no_rsp", {busy, bus.rsp_valid}, 0);
    @(posedge clk);
    #1;
    issue(1'b0, 16'h7FFF, 16'h0001, op_add, 1'b1, 16'h8000, 4'b0011, 2);
    drain();
    check("final_queue_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/alu16_sched.md
Name: alu16_sched

Overview:
- Round-robin scheduler that shares one ALU16 instance between two requesters over valid/ready handshakes.
- Sequences multi-bit shifts by iterating the ALU's single-bit shift ops, feeding the result back as the next operand.
- Returns the registered result and flags on a single response channel tagged with the requester id.
- Sits between the issue logic and the ALU16 datapath.

Parameters:
- WIDTH, 16, operand/result width (must match ALU16).
- OPW, 4, opcode width (ALU16 control).
- SHW, 4, shift-count width, taken from b[SHW-1:0] for shift ops.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req0_valid  in  1  requester 0 has an op.
- req0_ready  out  1  requester 0 op accepted this cycle.
- req0_a, req0_b  in  WIDTH  operands.
- req0_op  in  OPW  ALU16 control code.
- req1_valid, req1_ready, req1_a, req1_b, req1_op: same for requester 1.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  consumer takes response.
- rsp_id  out  1  requester id of response.
- rsp_out  out  WIDTH  result.
- rsp_flags  out  4  {zero, carry, overflow, negative}.
- busy  out  1  high in any state other than IDLE.
- alu_a, alu_b  out  WIDTH  to ALU16 a/b.
- alu_control  out  OPW  to ALU16 control.
- alu_out  in  WIDTH  from ALU16.
- alu_zero, alu_carry, alu_overflow, alu_negative  in  1  ALU16 flags.

Behaviour:
- Reset (async, rst_n low):
  - state = IDLE; acc, b_reg, op_reg, cnt, rsp_out, rsp_flags, rsp_id = 0; last_grant = 1, so req0 wins the first tie.
  - rsp_valid, req*_ready, busy = 0; alu_a/alu_b/alu_control = 0.
  - An in-flight op is discarded with no response.
- Opcodes:
  - 0000 add, 0001 sub, 0010 and, 0011 or, 0100 xor.
  - 0101 sll, 0110 srl, 0111 sra: ALU16 shifts by 1 per pass.
  - op[3]=1 is reserved.
- ALU drive: alu_a = acc, alu_b = b_reg, alu_control = op_reg, all sourced from registers only (no combinational path from req ports).
- IDLE:
  - Grant selection: if only one valid, grant it; if both, grant the one not equal to last_grant.
  - req_ready is asserted combinationally for the granted requester only, and only in IDLE.
  - On accept, capture a→acc, b→b_reg, op→op_reg, id→rsp_id, b[SHW-1:0]→cnt, and update last_grant.
  - Next state after accept:
    - Reserved op → RESP with out=0, flags=4'b1000.
    - Shift op with cnt=0 → RESP with out=a, flags={a==0, 0, 0, a[WIDTH-1]}.
    - Otherwise → EXEC.
- EXEC:
  - Non-shift: one cycle; capture alu_out and flags into rsp_out/rsp_flags; → RESP.
  - Shift: each cycle acc ← alu_out and cnt ← cnt-1.
  - When cnt==1, also capture alu_out and flags into rsp; → RESP. Flags come from the final pass.
- RESP:
  - rsp_valid=1; rsp_* held stable until rsp_ready.
  - Handshake → IDLE.
  - No new accept until back in IDLE, i.e. no accept in the handshake cycle.
- Latency, from accept cycle T:
  - Non-shift: rsp_valid at T+2.
  - Shift by n≥1: rsp_valid at T+1+n.
  - Shift by 0 or reserved op: rsp_valid at T+1.
  - Max throughput: one op per 3 cycles (non-shift, rsp_ready held high).
- A requester dropping valid before ready is legal; it is simply not granted.

Test Plan:
1. Simple add: req0 add a=0x0001 b=0x0001, rsp_ready=1 → rsp_out=0x0002, rsp_id=0, flags=0000, rsp_valid exactly 2 cycles after req0_ready.
2. Round-robin: both valid from reset, req0 sub 0x0002-0x0001, req1 and 0x000F&0x00F0, both held valid for 4 ops → grant order 0,1,0,1; responses 0x0001 (flags 0000) and 0x0000 (flags 1000).
3. Multi-bit shifts:
   - req1 sll a=0x0001 b=0x0004 → alu_control=0101 for 4 EXEC cycles, rsp_out=0x0010 at T+5.
   - sra a=0x8000 b=0x000F → 0xFFFF, negative=1.
4. Zero-count and reserved ops:
   - srl a=0x0002 b=0x0000 → rsp_out=0x0002 at T+1, no EXEC cycle.
   - op=4'b1000 → rsp_out=0x0000, flags=1000.
5. Backpressure: rsp_ready low 3 cycles in RESP with req1_valid high → rsp_* stable, req1_ready=0, busy=1; accept of req1 occurs 1 cycle after handshake.
6. Reset mid-shift: rst_n low on 2nd EXEC cycle of sll by 8 → rsp_valid/busy drop immediately; after release the aborted op yields no response, and a new req0 add proceeds normally.
